// File: rtl/mips_pkg.sv
// Shared datapath widths and the write-back entry format used between the
// execute stages and the register file write port.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [4:0]  index;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending write-back entries. Exposes every slot in age
// order (oldest first) together with an occupancy-derived valid bit.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  wb_entry_t               push_entry_i,
    input  logic                    pop_i,
    output wb_entry_t               head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output wb_entry_t               age_entry_o [DEPTH],
    output logic [DEPTH-1:0]        age_valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full buffer is legal only when the head leaves this cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: every comb output gets a value before any branch, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the valid bits derived from count_q mask stale slots.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_entry_o[k] = mem_q[rd_ptr_q + PTR_W'(k)];
            age_valid_o[k] = (CNT_W'(k) < count_q);
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// Write-side initiator for the register file: buffers results, drains one per
// cycle when the port is free, and forwards pending values to decode reads.
module reg_writeback_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic [REG_ADDR_W-1:0]   res_index,
    input  logic [DATA_W-1:0]       res_data,
    input  logic                    port_busy,
    output logic [REG_ADDR_W-1:0]   rd_index,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    write_enable,
    input  logic [REG_ADDR_W-1:0]   rs_index,
    input  logic [REG_ADDR_W-1:0]   rt_index,
    input  logic [DATA_W-1:0]       rs_rf_data,
    input  logic [DATA_W-1:0]       rt_rf_data,
    output logic [DATA_W-1:0]       rs_data,
    output logic [DATA_W-1:0]       rt_data,
    output logic [$clog2(DEPTH):0]  pending
);

    wb_entry_t          head;
    wb_entry_t          push_entry;
    wb_entry_t          age_entry [DEPTH];
    logic [DEPTH-1:0]   age_valid;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;

    assign pop          = !empty && !port_busy;
    assign res_ready    = !full || pop;
    // Writes to register 0 are accepted from the producer but never queued.
    assign push         = res_valid && res_ready && (res_index != '0);
    assign push_entry   = '{index: res_index, data: res_data};

    assign write_enable = pop;
    assign rd_index     = pop ? head.index : '0;
    assign rd_data      = pop ? head.data  : '0;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (pending),
        .age_entry_o  (age_entry),
        .age_valid_o  (age_valid)
    );

    // Scan oldest to youngest so the last match, the youngest, overrides.
    always_comb begin
        rs_data = rs_rf_data;
        rt_data = rt_rf_data;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k] && (age_entry[k].index == rs_index)) begin
                rs_data = age_entry[k].data;
            end
            if (age_valid[k] && (age_entry[k].index == rt_index)) begin
                rt_data = age_entry[k].data;
            end
        end
        if (rs_index == '0) begin
            rs_data = '0;
        end
        if (rt_index == '0) begin
            rt_data = '0;
        end
    end

endmodule
